// File: rtl/led_seq_ctrl.sv
// ============================================================================
// Module   : led_seq_ctrl
// Brief    : Four-LED pattern sequencer with a valid/ready command port and
//            an internal step prescaler. Optional PWM dimming: LED_PWM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_seq_ctrl #(
    parameter int STEP_BASE = 12_500_000,
    parameter int DIV_RST   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_mode,
    input  logic [2:0] cmd_div,
`ifdef LED_PWM_EN
    input  logic [3:0] cmd_bright,
`endif
    output logic [3:0] led,
    output logic       busy,
    output logic       step_tick
);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_run    = 2'd1;
    localparam logic [1:0]  c_st_pause  = 2'd2;
    localparam logic [1:0]  c_op_stop   = 2'd0;
    localparam logic [1:0]  c_op_start  = 2'd1;
    localparam logic [1:0]  c_op_pause  = 2'd2;
    localparam logic [1:0]  c_op_set    = 2'd3;
    localparam logic [31:0] c_step_base = 32'(STEP_BASE);

    logic [1:0]  r_state;
    logic [1:0]  r_mode;
    logic [2:0]  r_div;
    logic [31:0] r_pre;
    logic [3:0]  r_pat;
    logic        r_dir;
    logic        r_ready;
    logic        r_busy;
    logic        r_tick;

    logic        w_accept;
    logic [31:0] w_term;
    logic [3:0]  w_next_pat;
    logic        w_next_dir;

    function automatic logic [3:0] init_pat(input logic [1:0] mode);
        case (mode)
            2'd2:    return 4'b0000;
            2'd3:    return 4'b1111;
            default: return 4'b0001;
        endcase
    endfunction

    assign w_accept = cmd_valid && r_ready;
    assign w_term   = (32'(r_div) + 32'd1) * c_step_base - 32'd1;

    always_comb begin
        w_next_pat = r_pat;
        w_next_dir = r_dir;
        case (r_mode)
            2'd0: w_next_pat = {r_pat[2:0], r_pat[3]};
            2'd1: begin
                // Direction flips on reaching either end; the end LED is shown once.
                if (r_dir) begin
                    if (r_pat[3]) begin
                        w_next_pat = r_pat >> 1;
                        w_next_dir = 1'b0;
                    end else begin
                        w_next_pat = r_pat << 1;
                    end
                end else begin
                    if (r_pat[0]) begin
                        w_next_pat = r_pat << 1;
                        w_next_dir = 1'b1;
                    end else begin
                        w_next_pat = r_pat >> 1;
                    end
                end
            end
            2'd2: w_next_pat = r_pat + 4'd1;
            2'd3: w_next_pat = ~r_pat;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_mode  <= 2'd0;
            r_div   <= 3'(DIV_RST);
            r_pre   <= 32'd0;
            r_pat   <= 4'b0000;
            r_dir   <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_ready <= !w_accept;
            r_tick  <= 1'b0;
            // An accepted command takes priority over a prescaler wrap.
            if (w_accept) begin
                case (cmd_op)
                    c_op_stop: begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                        r_pat   <= 4'b0000;
                        r_pre   <= 32'd0;
                    end
                    c_op_start: begin
                        r_state <= c_st_run;
                        r_busy  <= 1'b1;
                        r_pat   <= init_pat(r_mode);
                        r_pre   <= 32'd0;
                        r_dir   <= 1'b1;
                    end
                    c_op_pause: begin
                        if (r_state == c_st_run) begin
                            r_state <= c_st_pause;
                        end else if (r_state == c_st_pause) begin
                            r_state <= c_st_run;
                        end
                    end
                    c_op_set: begin
                        r_mode <= cmd_mode;
                        r_div  <= cmd_div;
                        if (r_state != c_st_idle) begin
                            r_pat <= init_pat(cmd_mode);
                            r_pre <= 32'd0;
                            r_dir <= 1'b1;
                        end
                    end
                endcase
            end else if (r_state == c_st_run) begin
                if (r_pre == w_term) begin
                    r_pre  <= 32'd0;
                    r_pat  <= w_next_pat;
                    r_dir  <= w_next_dir;
                    r_tick <= 1'b1;
                end else begin
                    r_pre <= r_pre + 32'd1;
                end
            end
        end
    end

`ifdef LED_PWM_EN
    logic [3:0] r_bright;
    logic [3:0] r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bright <= 4'd15;
            r_pwm    <= 4'd0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
            if (w_accept && (cmd_op == c_op_set)) begin
                r_bright <= cmd_bright;
            end
        end
    end

    assign led = r_pat & {4{r_pwm < r_bright}};
`else
    assign led = r_pat;
`endif

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign step_tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
// ============================================================================
// Module   : tb_led_seq_ctrl
// Brief    : Self-checking bench for led_seq_ctrl against a step-index model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_seq_ctrl;

    localparam int TB_SB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_mode;
    logic [2:0] cmd_div;
    logic [3:0] cmd_bright;
    logic [3:0] led;
    logic       busy;
    logic       step_tick;

    int vectors     = 0;
    int miscompares = 0;

    // Model: state (0 idle, 1 run, 2 pause), steps taken since reload, cycles into step.
    int m_st, m_mode, m_div, m_n, m_pre, m_bright, m_pwm;
    bit m_ready, m_tick, m_acc;

    led_seq_ctrl #(.STEP_BASE(TB_SB), .DIV_RST(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_mode   (cmd_mode),
        .cmd_div    (cmd_div),
`ifdef LED_PWM_EN
        .cmd_bright (cmd_bright),
`endif
        .led        (led),
        .busy       (busy),
        .step_tick  (step_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] pat(input int mode, input int n);
        case (mode)
            0: return 4'(1 << (n % 4));
            1: case (n % 6)
                   0: return 4'b0001;
                   1: return 4'b0010;
                   2: return 4'b0100;
                   3: return 4'b1000;
                   4: return 4'b0100;
                   default: return 4'b0010;
               endcase
            2: return 4'(n % 16);
            default: return (n % 2 == 0) ? 4'b1111 : 4'b0000;
        endcase
    endfunction

    function automatic logic [6:0] expv();
        logic [3:0] l;
        l = (m_st == 0) ? 4'b0000 : pat(m_mode, m_n);
`ifdef LED_PWM_EN
        if (!(m_pwm < m_bright)) l = 4'b0000;
`endif
        return {l, m_st != 0, m_tick, m_ready};
    endfunction

    task automatic model_reset();
        m_st = 0; m_mode = 0; m_div = 3; m_n = 0; m_pre = 0;
        m_bright = 15; m_pwm = 0; m_ready = 1; m_tick = 0; m_acc = 0;
    endtask

    // One clock edge: advance the model from the inputs seen at the edge.
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_acc  = cmd_valid && m_ready;
            m_tick = 0;
            if (m_acc) begin
                case (cmd_op)
                    2'd0: begin m_st = 0; m_n = 0; m_pre = 0; end
                    2'd1: begin m_st = 1; m_n = 0; m_pre = 0; end
                    2'd2: if (m_st == 1) m_st = 2; else if (m_st == 2) m_st = 1;
                    default: begin
                        m_mode = cmd_mode; m_div = cmd_div; m_bright = cmd_bright;
                        if (m_st != 0) begin m_n = 0; m_pre = 0; end
                    end
                endcase
            end else if (m_st == 1) begin
                m_pre++;
                if (m_pre == (m_div + 1) * TB_SB) begin
                    m_pre = 0; m_n++; m_tick = 1;
                end
            end
            m_ready = !m_acc;
            m_pwm = (m_pwm + 1) % 16;
        end
        #1;
        if (m_acc) cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] mode,
                        input logic [2:0] div, input logic [3:0] br);
        cmd_valid = 1'b1; cmd_op = op; cmd_mode = mode; cmd_div = div; cmd_bright = br;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 0; cmd_mode = 0; cmd_div = 0; cmd_bright = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({led, busy, step_tick, cmd_ready} !== 7'b0000_0_0_1) begin
            miscompares++;
            $display("FAIL reset: got %b want %b", {led, busy, step_tick, cmd_ready}, 7'b0000001);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_walk();
        send(2'd1, 2'd0, 3'd0, 4'd15);
        for (int i = 0; i < 75; i++) begin
            cyc();
            vectors++;
            if ({led, busy, step_tick, cmd_ready} !== expv()) begin
                miscompares++;
                $display("FAIL walk cyc %0d: got %b want %b", i, {led, busy, step_tick, cmd_ready}, expv());
            end
        end
    endtask

    task automatic test_pingpong();
        send(2'd3, 2'd1, 3'd0, 4'd15);
        cyc();
        cyc();
        send(2'd1, 2'd0, 3'd0, 4'd15);
        for (int i = 0; i < 40; i++) begin
            cyc();
            vectors++;
            if ({led, busy, step_tick, cmd_ready} !== expv()) begin
                miscompares++;
                $display("FAIL pingpong cyc %0d: got %b want %b", i, {led, busy, step_tick, cmd_ready}, expv());
            end
        end
    endtask

    task automatic test_pause();
        int guard;
        send(2'd3, 2'd2, 3'd3, 4'd15);
        cyc();
        cyc();
        send(2'd1, 2'd0, 3'd0, 4'd15);
        guard = 0;
        do begin
            cyc();
            guard++;
        end while (!(m_n == 5 && m_pre == 7) && guard < 200);
        vectors++;
        if (led !== 4'b0101) begin
            miscompares++;
            $display("FAIL pause_setup: got led %b want 0101 (guard %0d)", led, guard);
        end
        send(2'd2, 2'd0, 3'd0, 4'd15);
        for (int i = 0; i < 52; i++) begin
            cyc();
            vectors++;
            if ({led, busy, step_tick, cmd_ready} !== expv()) begin
                miscompares++;
                $display("FAIL pause_hold cyc %0d: got %b want %b", i, {led, busy, step_tick, cmd_ready}, expv());
            end
        end
        send(2'd2, 2'd0, 3'd0, 4'd15);
        for (int i = 0; i < 40; i++) begin
            cyc();
            vectors++;
            if ({led, busy, step_tick, cmd_ready} !== expv()) begin
                miscompares++;
                $display("FAIL pause_resume cyc %0d: got %b want %b", i, {led, busy, step_tick, cmd_ready}, expv());
            end
        end
    endtask

    task automatic test_restart_at_t();
        int guard;
        send(2'd3, 2'd0, 3'd0, 4'd15);
        cyc();
        cyc();
        send(2'd1, 2'd0, 3'd0, 4'd15);
        guard = 0;
        do begin
            cyc();
            guard++;
        end while (!(m_st == 1 && m_n >= 2 && m_pre == TB_SB - 1 && !cmd_valid) && guard < 100);
        send(2'd1, 2'd0, 3'd0, 4'd15);
        for (int i = 0; i < 6; i++) begin
            cyc();
            vectors++;
            if ({led, busy, step_tick, cmd_ready} !== expv()) begin
                miscompares++;
                $display("FAIL restart_at_T cyc %0d: got %b want %b", i, {led, busy, step_tick, cmd_ready}, expv());
            end
        end
    endtask

    task automatic test_stop_reset();
        send(2'd3, 2'd3, 3'd1, 4'd15);
        cyc();
        cyc();
        send(2'd1, 2'd0, 3'd0, 4'd15);
        for (int i = 0; i < 60; i++) begin
            if (i == 20) send(2'd0, 2'd0, 3'd0, 4'd15);
            if (i == 26) send(2'd2, 2'd0, 3'd0, 4'd15);
            if (i == 34) send(2'd1, 2'd0, 3'd0, 4'd15);
            cyc();
            vectors++;
            if ({led, busy, step_tick, cmd_ready} !== expv()) begin
                miscompares++;
                $display("FAIL stop_idle cyc %0d: got %b want %b", i, {led, busy, step_tick, cmd_ready}, expv());
            end
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({led, busy, step_tick, cmd_ready} !== 7'b0000_0_0_1) begin
            miscompares++;
            $display("FAIL async_reset: got %b want %b", {led, busy, step_tick, cmd_ready}, 7'b0000001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(2'd1, 2'd0, 3'd0, 4'd15);
        for (int i = 0; i < 40; i++) begin
            cyc();
            vectors++;
            if ({led, busy, step_tick, cmd_ready} !== expv()) begin
                miscompares++;
                $display("FAIL post_reset_div cyc %0d: got %b want %b", i, {led, busy, step_tick, cmd_ready}, expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            if (!(cmd_valid && !m_ready)) begin
                cmd_valid  = ($urandom_range(0, 5) == 0);
                cmd_op     = 2'($urandom_range(0, 3));
                cmd_mode   = 2'($urandom_range(0, 3));
                cmd_div    = 3'($urandom_range(0, 7));
                cmd_bright = 4'($urandom_range(0, 15));
            end
            cyc();
            vectors++;
            if ({led, busy, step_tick, cmd_ready} !== expv()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %b want %b", i, {led, busy, step_tick, cmd_ready}, expv());
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_walk();
        test_pingpong();
        test_pause();
        test_restart_at_t();
        test_stop_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
